// File: rtl/mult_pkg.sv
// Shared multiplier-path definitions: operand/product widths and splitter FSM states.
package mult_pkg;
  localparam int PROD_W = 32;
  localparam int OPND_W = 16;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} split_state_t;
endpackage

// File: rtl/result_splitter.sv
// Narrows one 32-bit product word into 16-bit beats (low half first) over
// valid/ready on both sides, flagging products that overflow 16 bits.
module result_splitter
  import mult_pkg::*;
#(
  parameter int IN_W         = PROD_W,
  parameter int OUT_W        = OPND_W,
  parameter bit SKIP_ZERO_HI = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             overflow
);

  if (IN_W != 2*OUT_W) begin : g_bad_width
    $error("result_splitter: IN_W must equal 2*OUT_W");
  end

  split_state_t    state, state_n;
  logic [IN_W-1:0] hold;
  logic            ovf_q;
  logic            beat_xfer, take;

  always_comb begin
    out_valid = (state != IDLE);
    out_data  = '0;
    out_last  = 1'b0;
    overflow  = 1'b0;
    case (state)
      SEND_LO: begin
        out_data = hold[OUT_W-1:0];
        out_last = SKIP_ZERO_HI && !ovf_q;
        overflow = ovf_q;
      end
      SEND_HI: begin
        out_data = hold[IN_W-1:OUT_W];
        out_last = 1'b1;
        overflow = ovf_q;
      end
      default: ;
    endcase

    beat_xfer = out_valid && out_ready;
    // Last-beat term lets the next word load in the same cycle: no bubble.
    in_ready  = (state == IDLE) || (beat_xfer && out_last);
    take      = in_valid && in_ready;

    state_n = state;
    case (state)
      IDLE:    if (take) state_n = SEND_LO;
      SEND_LO: if (beat_xfer) state_n = out_last ? (take ? SEND_LO : IDLE) : SEND_HI;
      SEND_HI: if (beat_xfer) state_n = take ? SEND_LO : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        hold  <= in_data;
        ovf_q <= |in_data[IN_W-1:OUT_W];
      end
    end
  end

endmodule
